nios_fprint_spad_dualport_arb: RTL and testbench
================================================

// Module: nios_fprint_spad_dualport_arb
// PURPOSE
//  Parametrised per-core scratchpad: one single-port byte-enabled on-chip RAM shared by two Avalon-MM slaves.
//  s1 serves the Nios core data master; s2 serves the fingerprint/DMA unit.
//  Adds round-robin arbitration, waitrequest/readdatavalid pipelined reads and a hardware zeroize engine.
// PARAMETERS
//  DATA_W     32                                   data width, multiple of 8
//  ADDR_W     12                                   word address width; DEPTH = 2**ADDR_W
//  READ_LAT   1                                    read latency in cycles, 1 (unregistered q) or 2 (registered q)
//  INIT_FILE  "nios_fprint_processor_scratchpad.hex"  RAM init image
// PORTS
//  clk              in   1         system clock
//  reset_n          in   1         synchronous reset, active low
//  clken            in   1         global clock enable; low = freeze
//  sN_address       in   ADDR_W    word address (N = 1,2)
//  sN_byteenable    in   DATA_W/8  byte lanes for writes
//  sN_chipselect    in   1         request valid
//  sN_write         in   1         1 = write, 0 = read
//  sN_writedata     in   DATA_W    write data
//  sN_readdata      out  DATA_W    read data
//  sN_readdatavalid out  1         readdata valid strobe
//  sN_waitrequest   out  1         request not accepted this cycle
//  clear_req        in   1         start zeroize (pulse)
//  clear_busy       out  1         zeroize in progress
//  clear_done       out  1         one-cycle pulse at zeroize end
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): readdatavalid, readdata, clear_busy, clear_done = 0;
//   last_grant = s2 (s1 wins first tie). FSM -> ARB. Read pipeline flushed. RAM contents kept.
//  waitrequest is combinational: sN_waitrequest = sN_chipselect & ~grant_N; forced 1 while reset_n=0.
//  FSM states: ARB, CLEAR.
//   ARB -> CLEAR on clear_req & clken.
//   CLEAR -> ARB after the write to address DEPTH-1; clear_done pulses that same cycle.
//  Arbitration (ARB, clken=1):
//   - One request is granted per cycle. A lone request is granted.
//   - Simultaneous requests: grant the port != last_grant. last_grant updates on every grant.
//   - A masters with waitrequest=1 holds its request stable (Avalon rule).
//  Write: committed at the grant edge with byteenable masking. Disabled lanes are unchanged.
//   No readdatavalid is produced for writes.
//  Read: grant at edge T gives sN_readdatavalid=1 with data during cycle T+READ_LAT.
//   Port tag travels with the pipeline. Only the tagged port strobes; the other's readdata holds its last value.
//   Read-after-write to the same address in the next granted cycle returns the new data.
//   Back-to-back reads sustain 1 per cycle.
//  clken=0: no grants (waitrequest=1 on active requests); RAM, pipeline, FSM and clear counter frozen.
//   readdatavalid is forced 0 and the stalled beat is presented once clken returns.
//  CLEAR:
//   - Counter 0..DEPTH-1 writes all-zero, all lanes, one word per enabled cycle: DEPTH cycles total.
//   - clear_busy=1 from the cycle after acceptance until the cycle after clear_done.
//   - Both slaves see waitrequest=1.
//   - Reads issued before CLEAR drain normally.
//   - clear_req while busy is ignored.
//   - clear_req in the same cycle as an sN request: the clear wins, and the request waits.
//  Reset mid-CLEAR aborts; partially cleared contents remain and clear_done is not pulsed.
//  Address wrap is impossible: ADDR_W spans DEPTH exactly.
// STRUCTURE
//  Package nios_fprint_spad_pkg: state enum {ARB, CLEAR}, port-id enum {P_S1, P_S2}, BYTE_W=8 constant.
//  Sub-module nios_fprint_spad_ram: single-port RAM with byte enables, clock enable, INIT_FILE and optional output register (READ_LAT=2).
//   It is the only memory inference point.
//  Arbiter, read-tag pipeline and clear FSM are top-level logic.
// TESTING
//  1. Init file word0=0x11223344; s1 reads addr 0 -> s1_readdatavalid at T+READ_LAT, data 0x11223344; s2_readdatavalid stays 0.
//  2. s1 writes 0xDEADBEEF, be=4'b0101 to addr 0x10 over 0; read -> 0x00AD00EF.
//  3. s1 and s2 read continuously -> grants alternate s1,s2,s1,...; each waitrequest=1 on alternate cycles; no beat lost or misrouted.
//  4. clear_req, DEPTH=4096 -> clear_busy for 4096 cycles, single clear_done; s2 request held with waitrequest=1 then served; every address reads 0.
//  5. Toggle clken low for 3 cycles mid-read-burst -> no grants, readdatavalid=0, same data sequence afterwards.
//  6. reset_n low at clear count 100 -> busy=0, no done pulse, addr 99 reads 0, addr 200 keeps its old value.

Source files
------------

// File: rtl/nios_fprint_spad_pkg.sv
// Shared types for the dual-port scratchpad: controller states, port ids and lane width.
package nios_fprint_spad_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {ARB, CLEAR} state_t;
  typedef enum logic {P_S1, P_S2} port_t;
endpackage

// File: rtl/nios_fprint_spad_ram.sv
// Single-port byte-enabled RAM with clock enable; READ_LAT=2 adds an output register.
module nios_fprint_spad_ram
  import nios_fprint_spad_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 12,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = "nios_fprint_processor_scratchpad.hex"
) (
  input  logic                       clk,
  input  logic                       ce,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          q
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / BYTE_W;

  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q_p0;

  // stage p0: write commit and synchronous read
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
        end
      end
      q_p0 <= mem[addr];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_oreg
      logic [DATA_W-1:0] q_p1;
      // stage p1: optional output register
      always_ff @(posedge clk) begin
        if (ce) q_p1 <= q_p0;
      end
      assign q = q_p1;
    end else begin : g_noreg
      assign q = q_p0;
    end
  endgenerate
endmodule

// File: rtl/nios_fprint_spad_dualport_arb.sv
// Scratchpad shared by the Nios data master (s1) and the fingerprint/DMA unit (s2):
// round-robin arbitration, tagged read pipeline and a zeroize engine.
module nios_fprint_spad_dualport_arb
  import nios_fprint_spad_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 12,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = "nios_fprint_processor_scratchpad.hex"
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clken,
  input  logic [ADDR_W-1:0]        s1_address,
  input  logic [DATA_W/BYTE_W-1:0] s1_byteenable,
  input  logic                     s1_chipselect,
  input  logic                     s1_write,
  input  logic [DATA_W-1:0]        s1_writedata,
  output logic [DATA_W-1:0]        s1_readdata,
  output logic                     s1_readdatavalid,
  output logic                     s1_waitrequest,
  input  logic [ADDR_W-1:0]        s2_address,
  input  logic [DATA_W/BYTE_W-1:0] s2_byteenable,
  input  logic                     s2_chipselect,
  input  logic                     s2_write,
  input  logic [DATA_W-1:0]        s2_writedata,
  output logic [DATA_W-1:0]        s2_readdata,
  output logic                     s2_readdatavalid,
  output logic                     s2_waitrequest,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done
);
  localparam int NB = DATA_W / BYTE_W;

  state_t            state_q, state_d;
  port_t             last_grant_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              arb_en, grant1, grant2, clearing, rd_grant;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic              vld_p0, rd_vld;
  port_t             tag_p0, rd_tag;
  logic [DATA_W-1:0] hold1, hold2;

  // A pending clear request takes the cycle away from both slaves.
  assign arb_en   = reset_n & clken & (state_q == ARB) & ~clear_req;
  assign grant1   = arb_en & s1_chipselect & (~s2_chipselect | (last_grant_q == P_S2));
  assign grant2   = arb_en & s2_chipselect & ~grant1;
  assign rd_grant = (grant1 & ~s1_write) | (grant2 & ~s2_write);

  assign s1_waitrequest = ~reset_n | (s1_chipselect & ~grant1);
  assign s2_waitrequest = ~reset_n | (s2_chipselect & ~grant2);

  assign clearing   = reset_n & clken & (state_q == CLEAR);
  assign clear_done = clearing & (&clr_cnt_q);
  assign clear_busy = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (clear_req & clken) state_d = CLEAR;
      CLEAR:   if (clear_done) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    ram_we    = clearing | (grant1 & s1_write) | (grant2 & s2_write);
    ram_addr  = s1_address;
    ram_be    = s1_byteenable;
    ram_wdata = s1_writedata;
    if (clearing) begin
      ram_addr  = clr_cnt_q;
      ram_be    = '1;
      ram_wdata = '0;
    end else if (grant2) begin
      ram_addr  = s2_address;
      ram_be    = s2_byteenable;
      ram_wdata = s2_writedata;
    end
  end

  nios_fprint_spad_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .ce   (clken),
    .we   (ram_we),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  // stage p0: grant edge -- control state and read tag launch
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ARB;
      last_grant_q <= P_S2;
      clr_cnt_q    <= '0;
      vld_p0       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant1)      last_grant_q <= P_S1;
      else if (grant2) last_grant_q <= P_S2;
      if (state_q == ARB) clr_cnt_q <= '0;
      else if (clearing)  clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clken) vld_p0 <= rd_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (clken) tag_p0 <= grant2 ? P_S2 : P_S1;
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic  vld_p1;
      port_t tag_p1;
      // stage p1: tag follows the RAM output register
      always_ff @(posedge clk) begin
        if (!reset_n)   vld_p1 <= 1'b0;
        else if (clken) vld_p1 <= vld_p0;
      end
      always_ff @(posedge clk) begin
        if (clken) tag_p1 <= tag_p0;
      end
      assign rd_vld = vld_p1;
      assign rd_tag = tag_p1;
    end else begin : g_lat1
      assign rd_vld = vld_p0;
      assign rd_tag = tag_p0;
    end
  endgenerate

  // A stalled beat stays in the pipeline and is shown once clken returns.
  assign s1_readdatavalid = rd_vld & clken & (rd_tag == P_S1);
  assign s2_readdatavalid = rd_vld & clken & (rd_tag == P_S2);
  assign s1_readdata      = s1_readdatavalid ? ram_q : hold1;
  assign s2_readdata      = s2_readdatavalid ? ram_q : hold2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold1 <= '0;
      hold2 <= '0;
    end else begin
      if (s1_readdatavalid) hold1 <= ram_q;
      if (s2_readdatavalid) hold2 <= ram_q;
    end
  end
endmodule

// File: tb/tb_nios_fprint_spad_dualport_arb.sv
// Bench for the dual-port scratchpad: vector table, directed corner sequences and a
// randomized run against a transaction-level model.
module tb_nios_fprint_spad_dualport_arb;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 12;
  localparam int READ_LAT = 1;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int NB       = DATA_W / 8;
  localparam int RND_N    = 3000;

  logic              clk = 1'b0;
  logic              reset_n, clken, clear_req, clear_busy, clear_done;
  logic [ADDR_W-1:0] s1_address, s2_address;
  logic [NB-1:0]     s1_byteenable, s2_byteenable;
  logic              s1_chipselect, s2_chipselect, s1_write, s2_write;
  logic [DATA_W-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic              s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

  always #5 clk = ~clk;

  nios_fprint_spad_dualport_arb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    clear_req = 0;
  endtask

  task automatic drive_req(input int port, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [NB-1:0] be, input logic [DATA_W-1:0] wd);
    if (port == 1) begin
      s1_chipselect = 1; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = wd;
    end else begin
      s2_chipselect = 1; s2_write = wr; s2_address = a; s2_byteenable = be; s2_writedata = wd;
    end
  endtask

  task automatic do_reset();
    to_drive();
    reset_n = 0;
    clken = 1;
    idle();
    repeat (2) to_drive();
    reset_n = 1;
  endtask

  // Called at a drive point of the cycle after the grant edge.
  task automatic wait_beat(input int port, output bit found, output int lat,
                           output logic [DATA_W-1:0] data, output bit other);
    found = 0; lat = 0; data = '0; other = 0;
    for (int l = 1; l <= 8; l++) begin
      to_sample();
      if (port == 1 ? s2_readdatavalid : s1_readdatavalid) other = 1;
      if (port == 1 ? s1_readdatavalid : s2_readdatavalid) begin
        found = 1; lat = l; data = (port == 1) ? s1_readdata : s2_readdata;
        break;
      end
      to_drive();
    end
  endtask

  task automatic xfer(input string name, input int port, input bit wr, input logic [ADDR_W-1:0] a,
                      input logic [NB-1:0] be, input logic [DATA_W-1:0] wd,
                      input logic [DATA_W-1:0] exp);
    bit acc, found, other;
    int lat;
    logic [DATA_W-1:0] rd;
    to_drive();
    drive_req(port, wr, a, be, wd);
    acc = 0;
    for (int w = 0; w < 32; w++) begin
      to_sample();
      if (port == 1 ? !s1_waitrequest : !s2_waitrequest) begin acc = 1; break; end
      to_drive();
    end
    chk({name, "_accept"}, acc, 1);
    to_drive();
    idle();
    if (!wr && acc) begin
      wait_beat(port, found, lat, rd, other);
      chk({name, "_latency"}, lat, READ_LAT);
      chk({name, "_data"}, rd, exp);
      chk({name, "_other_port_quiet"}, other, 0);
    end
  endtask

  typedef struct {
    string             name;
    int                port;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] exp;
  } vec_t;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
    int                k;
  } beat_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "time limit reached");
  end

  initial begin
    vec_t              tbl [10];
    beat_t             inflight [$];
    beat_t             nb_t;
    logic [DATA_W-1:0] mdl [32];
    logic [DATA_W-1:0] hold [1:2];
    bit                pend [1:2];
    bit                pwr [1:2];
    logic [ADDR_W-1:0] pa [1:2];
    logic [NB-1:0]     pbe [1:2];
    logic [DATA_W-1:0] pwd [1:2];
    logic [DATA_W-1:0] rd, w;
    int busy_cnt, done_cnt, done_at, wait_bad, nbeats, nz, nwait, lat, last, g, ep, stall;
    bit served, found, other, en, gen;

    tbl[0] = '{"w_word0",   1, 1, 12'h000, 4'hF, 32'h11223344, 32'h0};
    tbl[1] = '{"r_word0",   1, 0, 12'h000, 4'hF, 32'h0,        32'h11223344};
    tbl[2] = '{"w_zero10",  1, 1, 12'h010, 4'hF, 32'h00000000, 32'h0};
    tbl[3] = '{"w_be0101",  1, 1, 12'h010, 4'b0101, 32'hDEADBEEF, 32'h0};
    tbl[4] = '{"r_be0101",  1, 0, 12'h010, 4'hF, 32'h0,        32'h00AD00EF};
    tbl[5] = '{"r_s2_10",   2, 0, 12'h010, 4'hF, 32'h0,        32'h00AD00EF};
    tbl[6] = '{"w_s2_top",  2, 1, 12'hFFF, 4'hF, 32'hCAFEF00D, 32'h0};
    tbl[7] = '{"w_s2_b3",   2, 1, 12'hFFF, 4'b1000, 32'h12345678, 32'h0};
    tbl[8] = '{"r_s1_top",  1, 0, 12'hFFF, 4'hF, 32'h0,        32'h12FEF00D};
    tbl[9] = '{"r_s2_word0",2, 0, 12'h000, 4'hF, 32'h0,        32'h11223344};

    // Reset state
    reset_n = 0; clken = 1; idle();
    s1_chipselect = 1;
    repeat (3) to_drive();
    to_sample();
    chk("rst_s1_wait", s1_waitrequest, 1);
    chk("rst_s2_wait_forced", s2_waitrequest, 1);
    to_drive();
    reset_n = 1;
    idle();
    to_sample();
    chk("rst_rdv1", s1_readdatavalid, 0);
    chk("rst_rdv2", s2_readdatavalid, 0);
    chk("rst_rd1", s1_readdata, 0);
    chk("rst_rd2", s2_readdata, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_s1_wait_idle", s1_waitrequest, 0);

    // Vector table
    for (int i = 0; i < 10; i++)
      xfer(tbl[i].name, tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wd, tbl[i].exp);

    // Continuous contention: s1 wins first tie after reset, then strict alternation
    do_reset();
    for (int i = 0; i < 10; i++) begin
      to_drive();
      drive_req(1, 0, 12'h010, 4'hF, '0);
      drive_req(2, 0, 12'hFFF, 4'hF, '0);
      to_sample();
      chk($sformatf("alt_s1_wait_%0d", i), s1_waitrequest, (i % 2) == 1);
      chk($sformatf("alt_s2_wait_%0d", i), s2_waitrequest, (i % 2) == 0);
      if (i >= READ_LAT) begin
        ep = ((i - READ_LAT) % 2 == 0) ? 1 : 2;
        chk($sformatf("alt_rdv1_%0d", i), s1_readdatavalid, ep == 1);
        chk($sformatf("alt_rdv2_%0d", i), s2_readdatavalid, ep == 2);
        if (ep == 1) chk($sformatf("alt_rd1_%0d", i), s1_readdata, 32'h00AD00EF);
        else         chk($sformatf("alt_rd2_%0d", i), s2_readdata, 32'h12FEF00D);
      end
    end
    to_drive();
    idle();
    repeat (READ_LAT + 2) to_drive();

    // Full zeroize with a colliding s2 read and an ignored re-request
    drive_req(2, 0, 12'h005, 4'hF, '0);
    clear_req = 1;
    to_sample();
    chk("clr_s2_wait_at_req", s2_waitrequest, 1);
    to_drive();
    clear_req = 0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; wait_bad = 0; served = 0;
    for (int c = 0; c < DEPTH + 64; c++) begin
      to_sample();
      if (clear_busy) begin
        busy_cnt++;
        if (!s2_waitrequest) wait_bad++;
      end
      if (clear_done) begin done_cnt++; done_at = busy_cnt; end
      if (!s2_waitrequest) begin served = 1; break; end
      to_drive();
      clear_req = (busy_cnt == 50);
    end
    chk("clr_busy_cycles", busy_cnt, DEPTH);
    chk("clr_done_count", done_cnt, 1);
    chk("clr_done_last_busy", done_at, DEPTH);
    chk("clr_s2_held", wait_bad, 0);
    chk("clr_s2_served", served, 1);
    to_drive();
    idle();
    wait_beat(2, found, lat, rd, other);
    chk("clr_s2_beat", found, 1);
    chk("clr_s2_data", rd, 0);

    nbeats = 0; nz = 0; nwait = 0;
    for (int i = 0; i < DEPTH + READ_LAT; i++) begin
      to_drive();
      if (i < DEPTH) drive_req(1, 0, i[ADDR_W-1:0], 4'hF, '0);
      else idle();
      to_sample();
      if (i < DEPTH && s1_waitrequest) nwait++;
      if (s1_readdatavalid) begin
        nbeats++;
        if (s1_readdata != 0) nz++;
      end
    end
    chk("sweep_beats", nbeats, DEPTH);
    chk("sweep_nonzero", nz, 0);
    chk("sweep_stalls", nwait, 0);

    // Randomized traffic with clken stalls against the transaction model
    do_reset();
    for (int a = 0; a < 32; a++) mdl[a] = '0;
    hold[1] = '0; hold[2] = '0;
    pend[1] = 0; pend[2] = 0;
    last = 2; stall = 0;
    for (int cyc = 0; cyc < RND_N + 200; cyc++) begin
      gen = (cyc < RND_N);
      if (!gen && !pend[1] && !pend[2] && inflight.size() == 0) break;
      to_drive();
      for (int p = 1; p <= 2; p++) begin
        if (!pend[p] && gen && $urandom_range(99) < 60) begin
          pend[p] = 1;
          pwr[p]  = ($urandom_range(2) == 0);
          pa[p]   = ADDR_W'($urandom_range(31));
          pbe[p]  = NB'($urandom);
          pwd[p]  = $urandom;
        end
      end
      if (stall > 0) begin en = 0; stall--; end
      else if (gen && $urandom_range(99) < 4) begin en = 0; stall = $urandom_range(2); end
      else en = 1;
      clken = en;
      idle();
      for (int p = 1; p <= 2; p++)
        if (pend[p]) drive_req(p, pwr[p], pa[p], pbe[p], pwd[p]);
      to_sample();

      ep = 0;
      if (en) begin
        for (int i = 0; i < inflight.size(); i++) inflight[i].k++;
        if (inflight.size() > 0 && inflight[0].k == READ_LAT) begin
          ep = inflight[0].port;
          hold[ep] = inflight[0].data;
          void'(inflight.pop_front());
        end
      end
      chk("rnd_rdv1", s1_readdatavalid, ep == 1);
      chk("rnd_rdv2", s2_readdatavalid, ep == 2);
      chk("rnd_rd1", s1_readdata, hold[1]);
      chk("rnd_rd2", s2_readdata, hold[2]);

      g = 0;
      if (en) begin
        if (pend[1] && pend[2]) g = (last == 1) ? 2 : 1;
        else if (pend[1])       g = 1;
        else if (pend[2])       g = 2;
      end
      chk("rnd_wait1", s1_waitrequest, pend[1] && g != 1);
      chk("rnd_wait2", s2_waitrequest, pend[2] && g != 2);
      if (g != 0) begin
        last = g;
        if (pwr[g]) begin
          w = mdl[pa[g][4:0]];
          for (int b = 0; b < NB; b++)
            if (pbe[g][b]) w[b*8 +: 8] = pwd[g][b*8 +: 8];
          mdl[pa[g][4:0]] = w;
        end else begin
          nb_t.port = g; nb_t.data = mdl[pa[g][4:0]]; nb_t.k = 0;
          inflight.push_back(nb_t);
        end
        pend[g] = 0;
      end
    end
    chk("rnd_drained", (inflight.size() == 0) && !pend[1] && !pend[2], 1);
    to_drive();
    clken = 1;
    idle();

    // Reset while zeroize is at word 100
    xfer("pre_w99", 1, 1, 12'd99, 4'hF, 32'hA5A5A599, '0);
    xfer("pre_w200", 2, 1, 12'd200, 4'hF, 32'h5A5A5A5A, '0);
    to_drive();
    clear_req = 1;
    to_sample();
    to_drive();
    clear_req = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      to_sample();
      if (clear_busy) busy_cnt++;
      if (clear_done) done_cnt++;
      if (busy_cnt == 100) break;
      to_drive();
    end
    chk("abort_reached_100", busy_cnt, 100);
    to_drive();
    reset_n = 0;
    to_sample();
    if (clear_done) done_cnt++;
    to_drive();
    to_sample();
    chk("abort_busy_in_reset", clear_busy, 0);
    to_drive();
    reset_n = 1;
    to_sample();
    chk("abort_busy_after", clear_busy, 0);
    chk("abort_no_done", done_cnt, 0);
    xfer("abort_r99", 1, 0, 12'd99, 4'hF, '0, 32'h0);
    xfer("abort_r0", 2, 0, 12'd0, 4'hF, '0, 32'h0);
    xfer("abort_r200", 1, 0, 12'd200, 4'hF, '0, 32'h5A5A5A5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
